// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter
// Shares one downstream AXI4 slave port between two AXI4 masters
// (m0 = instruction fetch, m1 = load/store). Exactly one whole
// transaction (AR/R or AW/W/B) is in flight at a time; the FSM returns
// to IDLE after every transaction.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   m0_* / m1_*           AXI4 master-side channels (AR, R, AW, W, B)
//   s_*                   AXI4 slave-side channels, mirror of m<i>_*
//   busy                  a transaction is in flight (state != IDLE)
//   grant                 index of granted master, valid while busy
//   fsm_state             current FSM state, for observation
//
// Configuration macro
//   ARB_ROUND_ROBIN_EN    defined: round-robin between masters, the master
//                         granted last loses the next contention.
//                         undefined: fixed priority, m1 over m0.
//
// Handshake semantics: a channel transfers on a cycle where valid and
// ready are both high. Valid/ready toward a master are only ever driven
// for the registered grant, so no master valid reaches a master ready
// without first passing through the grant register.
module axi_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  // master 0
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [3:0]        m0_arid,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic [3:0]        m0_rid,
  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic [ADDR_W-1:0] m0_awaddr,
  input  logic [3:0]        m0_awid,
  input  logic [7:0]        m0_awlen,
  input  logic [2:0]        m0_awsize,
  input  logic [1:0]        m0_awburst,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic              m0_wlast,
  output logic              m0_bvalid,
  input  logic              m0_bready,
  output logic [1:0]        m0_bresp,
  output logic [3:0]        m0_bid,
  // master 1
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [3:0]        m1_arid,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic [3:0]        m1_rid,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic [3:0]        m1_awid,
  input  logic [7:0]        m1_awlen,
  input  logic [2:0]        m1_awsize,
  input  logic [1:0]        m1_awburst,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic              m1_wlast,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  output logic [1:0]        m1_bresp,
  output logic [3:0]        m1_bid,
  // slave
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [3:0]        s_arid,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic [3:0]        s_rid,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic [3:0]        s_awid,
  output logic [7:0]        s_awlen,
  output logic [2:0]        s_awsize,
  output logic [1:0]        s_awburst,
  output logic              s_wvalid,
  input  logic              s_wready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic              s_wlast,
  input  logic              s_bvalid,
  output logic              s_bready,
  input  logic [1:0]        s_bresp,
  input  logic [3:0]        s_bid,
  // status
  output logic              busy,
  output logic              grant,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   req0, req1, win;

  assign req0 = m0_arvalid | m0_awvalid;
  assign req1 = m1_arvalid | m1_awvalid;

`ifdef ARB_ROUND_ROBIN_EN
  logic last;
  // On contention the master not granted last time wins.
  assign win = (req0 & req1) ? ~last : req1;
`else
  assign win = req1;
`endif

  // Granted-master view of the request-side signals.
  logic g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;
  assign g_arvalid = grant ? m1_arvalid : m0_arvalid;
  assign g_rready  = grant ? m1_rready  : m0_rready;
  assign g_awvalid = grant ? m1_awvalid : m0_awvalid;
  assign g_wvalid  = grant ? m1_wvalid  : m0_wvalid;
  assign g_bready  = grant ? m1_bready  : m0_bready;

  logic in_rd_addr, in_rd_data, aw_fwd, w_fwd, in_wr_resp;
  assign in_rd_addr = (state == RD_ADDR);
  assign in_rd_data = (state == RD_DATA);
  // Each write channel stops forwarding once its handshake has completed.
  assign aw_fwd     = (state == WR_ADDR) & ~aw_done;
  assign w_fwd      = (state == WR_ADDR) & ~w_done;
  assign in_wr_resp = (state == WR_RESP);

  // Slave side
  assign s_arvalid = in_rd_addr & g_arvalid;
  assign s_araddr  = grant ? m1_araddr  : m0_araddr;
  assign s_arid    = grant ? m1_arid    : m0_arid;
  assign s_arlen   = grant ? m1_arlen   : m0_arlen;
  assign s_arsize  = grant ? m1_arsize  : m0_arsize;
  assign s_arburst = grant ? m1_arburst : m0_arburst;
  assign s_rready  = in_rd_data & g_rready;
  assign s_awvalid = aw_fwd & g_awvalid;
  assign s_awaddr  = grant ? m1_awaddr  : m0_awaddr;
  assign s_awid    = grant ? m1_awid    : m0_awid;
  assign s_awlen   = grant ? m1_awlen   : m0_awlen;
  assign s_awsize  = grant ? m1_awsize  : m0_awsize;
  assign s_awburst = grant ? m1_awburst : m0_awburst;
  assign s_wvalid  = w_fwd & g_wvalid;
  assign s_wdata   = grant ? m1_wdata : m0_wdata;
  assign s_wstrb   = grant ? m1_wstrb : m0_wstrb;
  assign s_wlast   = grant ? m1_wlast : m0_wlast;
  assign s_bready  = in_wr_resp & g_bready;

  // Master side: handshake signals only toward the granted master.
  assign m0_arready = in_rd_addr & s_arready & ~grant;
  assign m1_arready = in_rd_addr & s_arready &  grant;
  assign m0_rvalid  = in_rd_data & s_rvalid  & ~grant;
  assign m1_rvalid  = in_rd_data & s_rvalid  &  grant;
  assign m0_awready = aw_fwd & s_awready & ~grant;
  assign m1_awready = aw_fwd & s_awready &  grant;
  assign m0_wready  = w_fwd & s_wready & ~grant;
  assign m1_wready  = w_fwd & s_wready &  grant;
  assign m0_bvalid  = in_wr_resp & s_bvalid & ~grant;
  assign m1_bvalid  = in_wr_resp & s_bvalid &  grant;

  // Payloads are qualified by valid, so both masters see the slave fields.
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rresp = s_rresp;
  assign m0_rlast = s_rlast;
  assign m1_rlast = s_rlast;
  assign m0_rid   = s_rid;
  assign m1_rid   = s_rid;
  assign m0_bresp = s_bresp;
  assign m1_bresp = s_bresp;
  assign m0_bid   = s_bid;
  assign m1_bid   = s_bid;

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  logic aw_hs, w_hs;
  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready & s_wlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant   <= win;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last    <= win;
`endif
            // A pending write wins over a pending read of the same master.
            if (win ? m1_awvalid : m0_awvalid) state <= WR_ADDR;
            else                               state <= RD_ADDR;
          end
        end
        RD_ADDR: if (s_arvalid & s_arready) state <= RD_DATA;
        RD_DATA: if (s_rvalid & s_rready & s_rlast) state <= IDLE;
        WR_ADDR: begin
          aw_done <= aw_done | aw_hs;
          w_done  <= w_done | w_hs;
          if ((aw_done | aw_hs) & (w_done | w_hs)) state <= WR_RESP;
        end
        WR_RESP: begin
          if (s_bvalid & s_bready) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Testbench for axi_mem_arbiter: table of single reads plus directed
// sequences for contention, split write, slave error, write-before-read
// and reset during a read data phase.
module tb_axi_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // master-side signals, index = master number
  logic [1:0]          m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [1:0]          m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic [1:0]          m_bvalid, m_bready;
  logic [1:0][AW-1:0]  m_araddr, m_awaddr;
  logic [1:0][DW-1:0]  m_rdata, m_wdata;
  logic [1:0][DW/8-1:0] m_wstrb;
  logic [1:0][1:0]     m_rresp, m_bresp;
  logic [1:0][3:0]     m_rid, m_bid;

  // slave-side signals
  logic          s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic          s_bvalid, s_bready;
  logic [AW-1:0] s_araddr, s_awaddr;
  logic [DW-1:0] s_rdata, s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic [1:0]    s_rresp, s_bresp, s_arburst, s_awburst;
  logic [3:0]    s_arid, s_awid, s_rid, s_bid;
  logic [7:0]    s_arlen, s_awlen;
  logic [2:0]    s_arsize, s_awsize;
  logic          busy, grant;
  logic [2:0]    fsm_state;

  axi_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]), .m0_araddr(m_araddr[0]),
    .m0_arid(4'd1), .m0_arlen(8'd0), .m0_arsize(3'd3), .m0_arburst(2'd1),
    .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]), .m0_rdata(m_rdata[0]),
    .m0_rresp(m_rresp[0]), .m0_rlast(m_rlast[0]), .m0_rid(m_rid[0]),
    .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]), .m0_awaddr(m_awaddr[0]),
    .m0_awid(4'd1), .m0_awlen(8'd0), .m0_awsize(3'd3), .m0_awburst(2'd1),
    .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]), .m0_wdata(m_wdata[0]),
    .m0_wstrb(m_wstrb[0]), .m0_wlast(m_wlast[0]),
    .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]), .m0_bresp(m_bresp[0]), .m0_bid(m_bid[0]),
    .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]), .m1_araddr(m_araddr[1]),
    .m1_arid(4'd2), .m1_arlen(8'd0), .m1_arsize(3'd3), .m1_arburst(2'd1),
    .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]), .m1_rdata(m_rdata[1]),
    .m1_rresp(m_rresp[1]), .m1_rlast(m_rlast[1]), .m1_rid(m_rid[1]),
    .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]), .m1_awaddr(m_awaddr[1]),
    .m1_awid(4'd2), .m1_awlen(8'd0), .m1_awsize(3'd3), .m1_awburst(2'd1),
    .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]), .m1_wdata(m_wdata[1]),
    .m1_wstrb(m_wstrb[1]), .m1_wlast(m_wlast[1]),
    .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]), .m1_bresp(m_bresp[1]), .m1_bid(m_bid[1]),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .busy(busy), .grant(grant), .fsm_state(fsm_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_arvalid = '0; m_rready = '0; m_awvalid = '0; m_wvalid = '0; m_wlast = '0;
    m_bready = '0; m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
    s_rid = '0; s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
    s_bid = '0;
  endtask

  // Entered in RD_ADDR for master m; completes AR and one R beat, leaves
  // the FSM in IDLE.
  task automatic finish_read(input int m, input logic [63:0] rdata, input logic [1:0] rresp);
    s_arready = 1'b1;
    #1;
    check("rd_arready", m_arready[m], 1'b1);
    check("rd_arready_other", m_arready[1-m], 1'b0);
    tick();
    m_arvalid[m] = 1'b0;
    s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = rdata; s_rresp = rresp; s_rlast = 1'b1;
    #1;
    check("rd_rvalid", m_rvalid[m], 1'b1);
    check("rd_rvalid_other", m_rvalid[1-m], 1'b0);
    check("rd_rdata", m_rdata[m], rdata);
    check("rd_rresp", m_rresp[m], rresp);
    check("rd_s_rready", s_rready, 1'b1);
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    check("rd_done_idle", busy, 1'b0);
  endtask

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } rd_vec_t;

  rd_vec_t vecs[4];

  initial begin
    vecs[0] = '{0, 32'h8000_0000, 64'h13, 2'b00, 64'h13, 2'b00};
    vecs[1] = '{1, 32'h0000_1000, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 64'hDEAD_BEEF_CAFE_F00D, 2'b00};
    vecs[2] = '{1, 32'h1000_0008, 64'h55, 2'b10, 64'h55, 2'b10};
    vecs[3] = '{0, 32'h0000_0004, 64'hA5A5_0000_0000_5A5A, 2'b11, 64'hA5A5_0000_0000_5A5A, 2'b11};

    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, 1'b0);
    check("rst_state", fsm_state, 3'd0);
    check("rst_s_valids", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 5'b0);
    check("rst_m_handshake", {m_arready, m_rvalid, m_awready, m_wready, m_bvalid}, 10'b0);

    // Single reads from the table
    for (int i = 0; i < 4; i++) begin
      int m;
      m = vecs[i].m;
      m_arvalid[m] = 1'b1; m_araddr[m] = vecs[i].addr; m_rready[m] = 1'b1;
      s_arready = 1'b1;
      #1;
      check("vec_no_comb_ready", m_arready[m], 1'b0);
      check("vec_idle_busy", busy, 1'b0);
      tick();
      check("vec_busy", busy, 1'b1);
      check("vec_grant", grant, m[0]);
      check("vec_s_arvalid", s_arvalid, 1'b1);
      check("vec_s_araddr", s_araddr, vecs[i].addr);
      finish_read(m, vecs[i].exp_rdata, vecs[i].exp_rresp);
      m_rready = '0;
      tick();
    end

    // Contention: both masters request in the same cycle; m1 first.
    m_arvalid = 2'b11; m_araddr[0] = 32'h100; m_araddr[1] = 32'h200; m_rready = 2'b11;
    tick();
    check("cont_first_grant", grant, 1'b1);
    check("cont_first_addr", s_araddr, 32'h200);
    finish_read(1, 64'h1111, 2'b00);
    check("cont_m0_pending", m_arvalid[0], 1'b1);
    tick();
    check("cont_second_grant", grant, 1'b0);
    check("cont_second_addr", s_araddr, 32'h100);
    finish_read(0, 64'h2222, 2'b00);
    m_rready = '0;
    tick();

    // Write with W two cycles ahead of AW (m1)
    m_wvalid[1] = 1'b1; m_wdata[1] = 64'h0123_4567_89AB_CDEF; m_wstrb[1] = 8'h0F;
    m_wlast[1] = 1'b1; m_bready[1] = 1'b1; s_wready = 1'b1;
    tick();
    check("wsplit_w_only_idle", busy, 1'b0);
    tick();
    check("wsplit_no_wready", m_wready[1], 1'b0);
    check("wsplit_no_s_wvalid", s_wvalid, 1'b0);
    m_awvalid[1] = 1'b1; m_awaddr[1] = 32'h2000_0010;
    tick();
    check("wsplit_state_wr_addr", fsm_state, 3'd3);
    check("wsplit_s_wvalid", s_wvalid, 1'b1);
    check("wsplit_s_wstrb", s_wstrb, 8'h0F);
    check("wsplit_s_awvalid", s_awvalid, 1'b1);
    check("wsplit_m1_wready", m_wready[1], 1'b1);
    tick();
    m_wvalid[1] = 1'b0; m_wlast[1] = 1'b0; s_wready = 1'b0;
    #1;
    check("wsplit_w_stopped", s_wvalid, 1'b0);
    check("wsplit_still_wr_addr", fsm_state, 3'd3);
    s_awready = 1'b1;
    #1;
    check("wsplit_m1_awready", m_awready[1], 1'b1);
    tick();
    m_awvalid[1] = 1'b0; s_awready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b00;
    #1;
    check("wsplit_wr_resp", fsm_state, 3'd4);
    check("wsplit_m1_bvalid", m_bvalid[1], 1'b1);
    check("wsplit_m0_bvalid", m_bvalid[0], 1'b0);
    check("wsplit_m1_bresp", m_bresp[1], 2'b00);
    tick();
    s_bvalid = 1'b0;
    #1;
    check("wsplit_idle", busy, 1'b0);
    tick();

    // Slave error on m1 write, AW and W together
    m_awvalid[1] = 1'b1; m_awaddr[1] = 32'hF000_0000; m_wvalid[1] = 1'b1;
    m_wlast[1] = 1'b1; m_wdata[1] = 64'h77; m_wstrb[1] = 8'hFF;
    s_awready = 1'b1; s_wready = 1'b1;
    tick();
    check("err_wr_addr", fsm_state, 3'd3);
    tick();
    m_awvalid[1] = 1'b0; m_wvalid[1] = 1'b0; m_wlast[1] = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b10;
    #1;
    check("err_state_resp", fsm_state, 3'd4);
    check("err_bresp", m_bresp[1], 2'b10);
    check("err_bvalid", m_bvalid[1], 1'b1);
    tick();
    s_bvalid = 1'b0; s_bresp = 2'b00; m_bready = '0;
    #1;
    check("err_idle", fsm_state, 3'd0);
    tick();

    // Same master AW and AR valid: write goes first
    m_awvalid[0] = 1'b1; m_awaddr[0] = 32'h3000; m_wvalid[0] = 1'b1; m_wlast[0] = 1'b1;
    m_wdata[0] = 64'hBEEF; m_wstrb[0] = 8'h03; m_bready[0] = 1'b1;
    m_arvalid[0] = 1'b1; m_araddr[0] = 32'h4000; m_rready[0] = 1'b1;
    s_arready = 1'b1;
    tick();
    check("awar_state_write", fsm_state, 3'd3);
    check("awar_no_s_arvalid", s_arvalid, 1'b0);
    check("awar_arready_low", m_arready[0], 1'b0);
    s_awready = 1'b1; s_wready = 1'b1;
    tick();
    m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0; m_wlast[0] = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b1;
    #1;
    check("awar_arready_in_resp", m_arready[0], 1'b0);
    tick();
    s_bvalid = 1'b0;
    #1;
    check("awar_idle_between", busy, 1'b0);
    tick();
    check("awar_read_state", fsm_state, 3'd1);
    check("awar_read_addr", s_araddr, 32'h4000);
    finish_read(0, 64'h9999, 2'b00);
    m_rready = '0; m_bready = '0;
    tick();

    // Reset asserted during RD_DATA
    m_arvalid[0] = 1'b1; m_araddr[0] = 32'h8000_0040; m_rready[0] = 1'b1; s_arready = 1'b1;
    tick();
    tick();
    m_arvalid[0] = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 64'hAB; s_rlast = 1'b0;
    #1;
    check("rstmid_rd_data", fsm_state, 3'd2);
    check("rstmid_rvalid_before", m_rvalid[0], 1'b1);
    rst = 1'b1;
    tick();
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_state", fsm_state, 3'd0);
    check("rstmid_rvalid", m_rvalid[0], 1'b0);
    check("rstmid_s_rready", s_rready, 1'b0);
    rst = 1'b0;
    clear_inputs();
    tick();
    check("rstmid_stays_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
